axi4_lite_write_master: RTL and testbench
=========================================

Name: axi4_lite_write_master

Overview:
AXI4-lite write initiator. It turns a single-beat store request from the core/LSU side into AW, W and B channel transactions towards an AXI4-lite write responder such as the data-memory write slave. One outstanding transaction at a time. All request fields are registered, so the core-side inputs need only be valid in the accept cycle.

Parameters:
ADDR_WIDTH  32  width of address, wr_addr and M_AXI_AWADDR
DATA_WIDTH  32  width of write data, wr_data and M_AXI_WDATA

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
wr_req  input  1  core requests a write; sampled only when wr_ready=1
wr_addr  input  ADDR_WIDTH  byte address of the write
wr_data  input  DATA_WIDTH  write data
wr_strb  input  4  byte enables
wr_ready  output  1  master idle and able to accept wr_req
wr_done  output  1  one-cycle pulse: response received
wr_err  output  1  valid with wr_done; 1 if BRESP[1]=1 (SLVERR/DECERR)
M_AXI_AWADDR  output  ADDR_WIDTH  write address
M_AXI_AWVALID  output  1  write address valid
M_AXI_AWREADY  input  1  slave accepts address
M_AXI_WDATA  output  DATA_WIDTH  write data
M_AXI_WSTRB  output  4  write strobes
M_AXI_WVALID  output  1  write data valid
M_AXI_WREADY  input  1  slave accepts data
M_AXI_BRESP  input  2  write response
M_AXI_BVALID  input  1  response valid
M_AXI_BREADY  output  1  master ready for response

Behaviour:
- Reset (async, any state):
  - state=ST_IDLE; AWVALID, WVALID, BREADY, wr_done and wr_err=0; AWADDR, WDATA and WSTRB registers=0.
  - Valids drop immediately, including mid-transaction. No completion is reported for an aborted transaction.
- State ST_IDLE:
  - wr_ready=1.
  - On wr_req=1 at a clock edge: latch addr/data/strb into the AXI output registers, set AWVALID=1 and WVALID=1, clear the aw_done and w_done flags, go to ST_WRITE.
  - wr_req with wr_ready=0 is ignored; no queueing.
- State ST_WRITE:
  - wr_ready=0.
  - AWVALID stays 1 until an edge where AWVALID&AWREADY. It then clears and sets aw_done. WVALID/WREADY/w_done behave the same way, independently.
  - AW and W handshakes may complete in either order, or in the same cycle.
  - Go to ST_BRESP on the edge where both handshakes are complete (flag set earlier, or completing now). BREADY=1 from the next cycle.
- State ST_BRESP:
  - BREADY=1.
  - On an edge with BVALID=1: BREADY=0, wr_done=1 for exactly one cycle, wr_err=BRESP[1], go to ST_IDLE.
  - wr_err holds its value until the next wr_done.
- AXI rules:
  - Valids never depend combinationally on readies. All AXI outputs are registered.
  - AWADDR, WDATA and WSTRB stay stable while their valid is high.
  - BRESP=OKAY(00)/EXOKAY(01) gives wr_err=0.
- Back-to-back: wr_done and wr_ready are both 1 in the first ST_IDLE cycle, and a new wr_req may be accepted in that same cycle.
- Latency with an always-ready slave that returns BVALID the cycle after AW/W:
  - wr_req accepted at edge 0; AW/W handshake at edge 1; BREADY high in cycle 2.
  - B accepted at edge 3 with the slave above (edge 2 if BVALID is already high); wr_done high in the cycle after B acceptance.
- Undefined state encodings return to ST_IDLE with all outputs deasserted.
- BVALID received outside ST_BRESP is ignored (BREADY=0).

Test Plan:
- Basic write:
  - Stimulus: wr_req with addr=0x0000_0010, data=0xDEADBEEF, strb=4'hF; slave always ready, BRESP=00.
  - Required: AWADDR=0x10 and WDATA=0xDEADBEEF held while valid; exactly one AW and one W handshake; wr_done pulses once with wr_err=0; wr_ready returns to 1.
- Skewed readies:
  - Stimulus: AWREADY delayed 3 cycles, WREADY immediate; then repeat with the delays swapped.
  - Required: WVALID drops after 1 cycle, AWVALID holds 4 cycles with a stable address; BREADY is asserted only after both handshakes; single wr_done.
- Response backpressure and error:
  - Stimulus: slave holds BVALID=0 for 5 cycles, then BVALID=1 with BRESP=2'b10.
  - Required: BREADY stays 1 throughout; wr_done and wr_err=1 after acceptance; wr_err holds until the next completion.
- Busy and back-to-back:
  - Stimulus: wr_req held high continuously during a transaction, with addresses 0x20 and then 0x24.
  - Required: the second request is accepted only in the wr_done cycle; no extra AW handshake occurs.
- Byte strobes:
  - Stimulus: strb=4'b0011, data=0x1234_5678, addr=0x40.
  - Required: WSTRB=0011 is observed at the W handshake.
- Reset mid-transaction:
  - Stimulus: assert rst while AWVALID=1 and AWREADY=0.
  - Required: AWVALID, WVALID and BREADY go to 0 immediately without waiting for a clock; no wr_done; after reset release, wr_ready=1 and a new write completes normally.

Source files
------------

// File: rtl/axi4_lite_write_master_if.sv
// Bundle of the core-side store request signals and the AXI4-lite AW/W/B channels that sit
// between a core/LSU, the write master and an AXI4-lite write responder.
//   master modport : used by axi4_lite_write_master (drives valids, AXI fields, BREADY, status)
//   slave  modport : the opposite view (core request source and AXI responder)
interface axi4_lite_write_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  // Core side
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_ready;
  logic                  wr_done;
  logic                  wr_err;
  // AXI4-lite write channels
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [3:0]            M_AXI_WSTRB;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;

  modport master (
    input  wr_req, wr_addr, wr_data, wr_strb,
    output wr_ready, wr_done, wr_err,
    output M_AXI_AWADDR, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    output wr_req, wr_addr, wr_data, wr_strb,
    input  wr_ready, wr_done, wr_err,
    input  M_AXI_AWADDR, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );
endinterface

// File: rtl/axi4_lite_write_master.sv
// AXI4-lite write initiator: accepts one single-beat store request from the core, issues it
// on the AW and W channels (independent handshakes, any order), then waits for the B response.
// One transaction outstanding; request fields are captured in the accept cycle.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : axi4_lite_write_master_if.master (core request/status + AXI AW/W/B channels)
module axi4_lite_write_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic                     clk,
  input logic                     rst,
  axi4_lite_write_master_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_BRESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_wr_done;
  logic                  r_wr_err;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_complete;
  logic w_w_complete;
  logic w_unused;

  assign w_aw_hs       = r_awvalid & bus.M_AXI_AWREADY;
  assign w_w_hs        = r_wvalid & bus.M_AXI_WREADY;
  // A channel counts as complete if it finished earlier or finishes at this edge.
  assign w_aw_complete = r_aw_done | w_aw_hs;
  assign w_w_complete  = r_w_done | w_w_hs;
  // Only BRESP[1] distinguishes error responses.
  assign w_unused      = bus.M_AXI_BRESP[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.wr_req) begin
            r_awaddr  <= bus.wr_addr;
            r_wdata   <= bus.wr_data;
            r_wstrb   <= bus.wr_strb;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_complete && w_w_complete) begin
            r_bready <= 1'b1;
            r_state  <= ST_BRESP;
          end
        end
        ST_BRESP: begin
          if (bus.M_AXI_BVALID) begin
            r_bready  <= 1'b0;
            r_wr_done <= 1'b1;
            r_wr_err  <= bus.M_AXI_BRESP[1];
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b0;
          r_bready  <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.wr_ready      = (r_state == ST_IDLE);
  assign bus.wr_done       = r_wr_done;
  assign bus.wr_err        = r_wr_err;
  assign bus.M_AXI_AWADDR  = r_awaddr;
  assign bus.M_AXI_AWVALID = r_awvalid;
  assign bus.M_AXI_WDATA   = r_wdata;
  assign bus.M_AXI_WSTRB   = r_wstrb;
  assign bus.M_AXI_WVALID  = r_wvalid;
  assign bus.M_AXI_BREADY  = r_bready;

endmodule

// File: tb/tb_axi4_lite_write_master.sv
// Bench for axi4_lite_write_master: table of directed writes, hand-written corner sequences
// (back-to-back, spurious BVALID, reset mid-transaction) and randomized writes, all checked
// against expectations derived from the transaction parameters.
module tb_axi4_lite_write_master;

  logic clk;
  logic rst;

  axi4_lite_write_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4_lite_write_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Responder configuration
  int         cfg_awd   = 0;
  int         cfg_wd    = 0;
  int         cfg_bd    = 0;
  logic [1:0] cfg_bresp = 2'b00;
  bit         b_spurious = 1'b0;

  // Expected fields while valids are high
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [3:0]  exp_strb = '0;

  // Monitor counters/captures
  int          aw_hs, w_hs, b_hs, done_cnt, aw_vcyc, w_vcyc, br_cyc, stab_err, early;
  logic [31:0] aw_addr_seen, w_data_seen;
  logic [3:0]  w_strb_seen;
  logic        err_seen;

  // Responder private state
  int aw_wait, w_wait, b_wait;
  bit s_aw, s_w, bv;

  logic model_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_mon();
    aw_hs = 0; w_hs = 0; b_hs = 0; done_cnt = 0; aw_vcyc = 0; w_vcyc = 0;
    br_cyc = 0; stab_err = 0; early = 0;
  endtask

  // Responder + monitor. Decisions made at the negedge take effect at the next rising edge,
  // so a handshake is counted here when both valid and ready are set for the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      bus.M_AXI_AWREADY = 1'b0;
      bus.M_AXI_WREADY  = 1'b0;
      bus.M_AXI_BVALID  = b_spurious;
      bus.M_AXI_BRESP   = cfg_bresp;
      aw_wait = 0; w_wait = 0; b_wait = 0; s_aw = 0; s_w = 0;
    end else begin
      if (bus.M_AXI_BREADY) begin
        br_cyc++;
        if (aw_hs == 0 || w_hs == 0) early++;
      end
      if (bus.M_AXI_AWVALID) begin
        aw_vcyc++;
        if (bus.M_AXI_AWADDR !== exp_addr) stab_err++;
      end
      if (bus.M_AXI_WVALID) begin
        w_vcyc++;
        if (bus.M_AXI_WDATA !== exp_data || bus.M_AXI_WSTRB !== exp_strb) stab_err++;
      end
      if (bus.wr_done) begin
        done_cnt++;
        err_seen = bus.wr_err;
      end
      bv = 1'b0;
      if (s_aw && s_w) begin
        bv = (b_wait >= cfg_bd);
        if (bv && bus.M_AXI_BREADY) begin
          b_hs++; s_aw = 0; s_w = 0; b_wait = 0;
        end else begin
          b_wait++;
        end
      end
      bus.M_AXI_BVALID = bv | b_spurious;
      bus.M_AXI_BRESP  = cfg_bresp;
      if (bus.M_AXI_AWVALID && !s_aw) begin
        bus.M_AXI_AWREADY = (aw_wait >= cfg_awd);
        if (bus.M_AXI_AWREADY) begin
          aw_hs++; s_aw = 1; aw_wait = 0; aw_addr_seen = bus.M_AXI_AWADDR;
        end else begin
          aw_wait++;
        end
      end else begin
        bus.M_AXI_AWREADY = 1'b0;
        aw_wait = 0;
      end
      if (bus.M_AXI_WVALID && !s_w) begin
        bus.M_AXI_WREADY = (w_wait >= cfg_wd);
        if (bus.M_AXI_WREADY) begin
          w_hs++; s_w = 1; w_wait = 0;
          w_data_seen = bus.M_AXI_WDATA; w_strb_seen = bus.M_AXI_WSTRB;
        end else begin
          w_wait++;
        end
      end else begin
        bus.M_AXI_WREADY = 1'b0;
        w_wait = 0;
      end
    end
  end

  // One complete write; called at posedge+1 with the master idle.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd, input int bd, input logic [1:0] br,
                          input logic exp_err);
    int k;
    bit got;
    cfg_awd = awd; cfg_wd = wd; cfg_bd = bd; cfg_bresp = br;
    exp_addr = a; exp_data = d; exp_strb = s;
    clear_mon();
    check("ready_before_req", bus.wr_ready, 1);
    check("err_held", bus.wr_err, model_err);
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s;
    @(posedge clk); #1;
    // Scramble the request fields: the master must use its captured copies.
    bus.wr_req = 1'b0; bus.wr_addr = $urandom; bus.wr_data = $urandom;
    bus.wr_strb = 4'($urandom);
    k = 0; got = 0;
    while (!got && k < 300) begin
      @(posedge clk); #1;
      k++;
      if (bus.wr_done) got = 1;
    end
    check("done_seen", got, 1);
    check("latency", k, imax(awd, wd) + bd + 2);
    check("ready_at_done", bus.wr_ready, 1);
    check("err_at_done", bus.wr_err, exp_err);
    @(posedge clk); #1;
    check("done_one_cycle", bus.wr_done, 0);
    check("done_count", done_cnt, 1);
    check("err_seen", err_seen, exp_err);
    check("aw_hs_count", aw_hs, 1);
    check("w_hs_count", w_hs, 1);
    check("b_hs_count", b_hs, 1);
    check("aw_valid_cycles", aw_vcyc, awd + 1);
    check("w_valid_cycles", w_vcyc, wd + 1);
    check("bready_cycles", br_cyc, bd + 1);
    check("stable_fields", stab_err, 0);
    check("bready_early", early, 0);
    check("awaddr", aw_addr_seen, a);
    check("wdata", w_data_seen, d);
    check("wstrb", w_strb_seen, s);
    model_err = exp_err;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          awd;
    int          wd;
    int          bd;
    logic [1:0]  bresp;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int  k;
    bit  got;
    int  busy_bad;
    logic [1:0] br;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 2'b00, 1'b0};
    vecs[1] = '{32'h0000_0014, 32'h0BAD_F00D, 4'hF, 3, 0, 1, 2'b00, 1'b0};
    vecs[2] = '{32'h0000_0018, 32'hCAFE_0001, 4'hF, 0, 3, 0, 2'b00, 1'b0};
    vecs[3] = '{32'h0000_001C, 32'h5555_AAAA, 4'hF, 0, 0, 5, 2'b10, 1'b1};
    vecs[4] = '{32'h0000_0040, 32'h1234_5678, 4'b0011, 0, 0, 0, 2'b00, 1'b0};
    vecs[5] = '{32'h0000_0044, 32'h0000_0001, 4'b1000, 1, 2, 2, 2'b01, 1'b0};
    vecs[6] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b0101, 2, 2, 0, 2'b11, 1'b1};

    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
    clear_mon();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_ready", bus.wr_ready, 1);
    check("rst_awvalid", bus.M_AXI_AWVALID, 0);
    check("rst_wvalid", bus.M_AXI_WVALID, 0);
    check("rst_bready", bus.M_AXI_BREADY, 0);
    check("rst_done", bus.wr_done, 0);
    check("rst_err", bus.wr_err, 0);
    check("rst_awaddr", bus.M_AXI_AWADDR, 0);
    check("rst_wdata", bus.M_AXI_WDATA, 0);
    check("rst_wstrb", bus.M_AXI_WSTRB, 0);

    // BVALID while idle must be ignored.
    b_spurious = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("spurious_bready", bus.M_AXI_BREADY, 0);
      check("spurious_done", bus.wr_done, 0);
    end
    b_spurious = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].awd, vecs[i].wd,
               vecs[i].bd, vecs[i].bresp, vecs[i].exp_err);

    // Back-to-back with wr_req held high: second request taken only in the wr_done cycle.
    cfg_awd = 1; cfg_wd = 0; cfg_bd = 1; cfg_bresp = 2'b00;
    exp_addr = 32'h20; exp_data = 32'hA5A5_0020; exp_strb = 4'hF;
    clear_mon();
    busy_bad = 0;
    bus.wr_req = 1'b1; bus.wr_addr = 32'h20; bus.wr_data = 32'hA5A5_0020; bus.wr_strb = 4'hF;
    k = 0; got = 0;
    while (!got && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (bus.wr_done) got = 1;
      else if (bus.wr_ready) busy_bad++;
    end
    check("b2b_first_done", got, 1);
    check("b2b_busy_ready", busy_bad, 0);
    check("b2b_single_aw", aw_hs, 1);
    check("b2b_ready_at_done", bus.wr_ready, 1);
    exp_addr = 32'h24; exp_data = 32'hA5A5_0024;
    bus.wr_addr = 32'h24; bus.wr_data = 32'hA5A5_0024;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    check("b2b_second_awvalid", bus.M_AXI_AWVALID, 1);
    check("b2b_second_awaddr", bus.M_AXI_AWADDR, 32'h24);
    k = 0; got = 0;
    while (!got && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (bus.wr_done) got = 1;
    end
    check("b2b_second_done", got, 1);
    @(posedge clk); #1;
    check("b2b_aw_total", aw_hs, 2);
    check("b2b_w_total", w_hs, 2);
    check("b2b_done_total", done_cnt, 2);
    check("b2b_addr_seen", aw_addr_seen, 32'h24);
    check("b2b_stable", stab_err, 0);
    model_err = 1'b0;

    // Reset while AWVALID=1 and AWREADY=0.
    cfg_awd = 20; cfg_wd = 20; cfg_bd = 0;
    exp_addr = 32'h80; exp_data = 32'h8080_8080; exp_strb = 4'hF;
    clear_mon();
    bus.wr_req = 1'b1; bus.wr_addr = 32'h80; bus.wr_data = 32'h8080_8080; bus.wr_strb = 4'hF;
    @(posedge clk); #1;
    bus.wr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_awvalid", bus.M_AXI_AWVALID, 1);
    check("pre_rst_awready", bus.M_AXI_AWREADY, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst_awvalid", bus.M_AXI_AWVALID, 0);
    check("async_rst_wvalid", bus.M_AXI_WVALID, 0);
    check("async_rst_bready", bus.M_AXI_BREADY, 0);
    check("async_rst_ready", bus.wr_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("rst_no_done", done_cnt, 0);
    check("rst_ready_after", bus.wr_ready, 1);
    model_err = 1'b0;
    do_write(32'h0000_0084, 32'h1357_9BDF, 4'hF, 0, 1, 1, 2'b00, 1'b0);

    // Randomized writes.
    for (int i = 0; i < 40; i++) begin
      br = 2'($urandom_range(0, 3));
      do_write($urandom, $urandom, 4'($urandom), $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 4), br, (br >= 2'd2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
